// File: rtl/guitar_fx_pkg.sv
// Shared definitions for the guitar effect chain.
// Holds the sequencer state encoding and the default data-path dimensions.
package guitar_fx_pkg;

   localparam int FX_DATA_WIDTH = 32;
   localparam int FX_N_SLOTS    = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_OUT   = 3'd4
   } fx_seq_state_t;

endpackage

// File: rtl/fx_chain_sequencer.sv
// fx_chain_sequencer
// Runs each captured audio sample through the enabled effect slots, in
// ascending slot order, over one shared effect unit. Each slot's result
// becomes the operand of the next enabled slot. A slot that does not answer
// within TIMEOUT wait cycles is bypassed and flagged.
//
// Ports:
//   CLK, rst           clock, asynchronous active-high reset
//   audio_ready, x     new-sample strobe and sample
//   slot_en            per-slot enables, latched with each sample
//   fx_start/slot/x    request to the shared effect unit (held through the wait)
//   fx_y, fx_done      effect unit result and completion pulse
//   y, y_valid         processed sample and its one-cycle update pulse
//   busy               high whenever a sample is in flight
//   indicator          enables latched for the current or last sample
//   overrun, fault     sticky flags: dropped sample / slot timeout
//   clr_flags          synchronous clear of the sticky flags (a set wins)
module fx_chain_sequencer
   import guitar_fx_pkg::*;
#(
   parameter int DATA_WIDTH = FX_DATA_WIDTH,
   parameter int N_SLOTS    = FX_N_SLOTS,
   parameter int TIMEOUT    = 64
)
(
   input  logic                       CLK,
   input  logic                       rst,
   input  logic                       audio_ready,
   input  logic [DATA_WIDTH-1:0]      x,
   input  logic [N_SLOTS-1:0]         slot_en,
   output logic                       fx_start,
   output logic [$clog2(N_SLOTS)-1:0] fx_slot,
   output logic [DATA_WIDTH-1:0]      fx_x,
   input  logic [DATA_WIDTH-1:0]      fx_y,
   input  logic                       fx_done,
   output logic [DATA_WIDTH-1:0]      y,
   output logic                       y_valid,
   output logic                       busy,
   output logic [N_SLOTS-1:0]         indicator,
   output logic                       overrun,
   output logic                       fault,
   input  logic                       clr_flags
);

   localparam int SLOT_W = $clog2(N_SLOTS);
   // The slot index must also be able to hold N_SLOTS, the end-of-chain marker.
   localparam int IDX_W  = $clog2(N_SLOTS + 1);
   localparam int CNT_W  = $clog2(TIMEOUT);

   fx_seq_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0]  acc_q, acc_d;
   logic [N_SLOTS-1:0]     en_q, en_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   fx_start_q, fx_start_d;
   logic [SLOT_W-1:0]      fx_slot_q, fx_slot_d;
   logic [DATA_WIDTH-1:0]  fx_x_q, fx_x_d;
   logic [DATA_WIDTH-1:0]  y_q, y_d;
   logic                   y_valid_q, y_valid_d;
   logic                   busy_q, busy_d;
   logic [N_SLOTS-1:0]     ind_q, ind_d;
   logic                   overrun_q, overrun_d;
   logic                   fault_q, fault_d;
   logic                   overrun_set_s;
   logic                   fault_set_s;

   // Next-state, data-path and flag logic for the slot sequencer.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      en_d          = en_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      fx_start_d    = 1'b0;
      fx_slot_d     = fx_slot_q;
      fx_x_d        = fx_x_q;
      y_d           = y_q;
      y_valid_d     = 1'b0;
      ind_d         = ind_q;
      fault_set_s   = 1'b0;
      // A strobe is only consumed in IDLE; anywhere else the sample is lost.
      overrun_set_s = audio_ready && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (audio_ready) begin
               acc_d   = x;
               en_d    = slot_en;
               ind_d   = slot_en;
               idx_d   = {IDX_W{1'b0}};
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (idx_q == IDX_W'(N_SLOTS)) begin
               state_d = ST_OUT;
            end else if (en_q[idx_q[SLOT_W-1:0]]) begin
               // Outputs are registered, so the request is loaded on the way
               // into ISSUE and is visible for exactly the ISSUE cycle.
               state_d    = ST_ISSUE;
               fx_start_d = 1'b1;
               fx_x_d     = acc_q;
               fx_slot_d  = idx_q[SLOT_W-1:0];
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = {CNT_W{1'b0}};
         end
         ST_WAIT: begin
            if (fx_done) begin
               acc_d   = fx_y;
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_SCAN;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               // Slot bypassed: the accumulator keeps the previous stage's value.
               fault_set_s = 1'b1;
               idx_d       = idx_q + IDX_W'(1);
               state_d     = ST_SCAN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_OUT: begin
            y_d       = acc_q;
            y_valid_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);

      // Sticky flags: a set event in the same cycle overrides the clear.
      if (overrun_set_s) begin
         overrun_d = 1'b1;
      end else if (clr_flags) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      if (fault_set_s) begin
         fault_d = 1'b1;
      end else if (clr_flags) begin
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q;
      end
   end

   // State and output registers; reset aborts any sequence in flight.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         acc_q      <= {DATA_WIDTH{1'b0}};
         en_q       <= {N_SLOTS{1'b0}};
         idx_q      <= {IDX_W{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         fx_start_q <= 1'b0;
         fx_slot_q  <= {SLOT_W{1'b0}};
         fx_x_q     <= {DATA_WIDTH{1'b0}};
         y_q        <= {DATA_WIDTH{1'b0}};
         y_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
         ind_q      <= {N_SLOTS{1'b0}};
         overrun_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         en_q       <= en_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         fx_start_q <= fx_start_d;
         fx_slot_q  <= fx_slot_d;
         fx_x_q     <= fx_x_d;
         y_q        <= y_d;
         y_valid_q  <= y_valid_d;
         busy_q     <= busy_d;
         ind_q      <= ind_d;
         overrun_q  <= overrun_d;
         fault_q    <= fault_d;
      end
   end

   assign fx_start  = fx_start_q;
   assign fx_slot   = fx_slot_q;
   assign fx_x      = fx_x_q;
   assign y         = y_q;
   assign y_valid   = y_valid_q;
   assign busy      = busy_q;
   assign indicator = ind_q;
   assign overrun   = overrun_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_fx_chain_sequencer.sv
// Directed self-checking bench for fx_chain_sequencer with a behavioural
// effect unit that answers each request after a programmable delay.
module tb_fx_chain_sequencer;

   logic        CLK = 1'b0;
   logic        rst;
   logic        audio_ready;
   logic [31:0] x;
   logic [3:0]  slot_en;
   logic        fx_start;
   logic [1:0]  fx_slot;
   logic [31:0] fx_x;
   logic [31:0] fx_y;
   logic        fx_done;
   logic [31:0] y;
   logic        y_valid;
   logic        busy;
   logic [3:0]  indicator;
   logic        overrun;
   logic        fault;
   logic        clr_flags;

   // Effect unit model outputs and bench-forced completion.
   logic        rsp_done;
   logic [31:0] rsp_y;
   logic        man_done;
   logic [31:0] man_y;
   int          resp_mode;   // 0: never answer, 1: x+1, 2: x*2
   int          resp_d;
   int          fs_count;
   logic [1:0]  slot_log [32];
   logic [31:0] x_log [32];
   int          yv_count;

   int          n_cmp;
   int          n_bad;
   int          lat;
   logic [31:0] yo;
   logic [31:0] probe_x;
   logic [1:0]  probe_slot;
   logic        probe_start;
   logic        probe_busy;
   int          fs0;
   int          yv0;

   assign fx_done = rsp_done | man_done;
   assign fx_y    = man_done ? man_y : rsp_y;

   fx_chain_sequencer dut (
      .CLK(CLK), .rst(rst), .audio_ready(audio_ready), .x(x), .slot_en(slot_en),
      .fx_start(fx_start), .fx_slot(fx_slot), .fx_x(fx_x), .fx_y(fx_y),
      .fx_done(fx_done), .y(y), .y_valid(y_valid), .busy(busy),
      .indicator(indicator), .overrun(overrun), .fault(fault),
      .clr_flags(clr_flags)
   );

   always #5 CLK = ~CLK;

   // Counts y_valid pulses, sampled away from the active edge.
   always @(negedge CLK) begin
      if (y_valid === 1'b1) yv_count <= yv_count + 1;
   end

   // Behavioural effect unit: logs each request and answers after resp_d waits.
   initial begin
      rsp_done = 1'b0;
      rsp_y    = 32'd0;
      fs_count = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (fx_start === 1'b1) begin
            if (fs_count < 32) begin
               slot_log[fs_count] = fx_slot;
               x_log[fs_count]    = fx_x;
            end
            fs_count++;
            if (resp_mode != 0) begin
               repeat (resp_d) @(posedge CLK);
               #1;
               rsp_y    = (resp_mode == 1) ? (fx_x + 32'd1) : (fx_x << 1);
               rsp_done = 1'b1;
               @(posedge CLK);
               #1;
               rsp_done = 1'b0;
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one sample and waits (bounded) for y_valid; lat is the cycle
   // number after the capture edge. extra_at injects a second strobe plus
   // clr_flags (kind 0) or a stray fx_done (kind 1) in that cycle.
   task automatic run_sample(input logic [31:0] xin, input logic [3:0] en,
                             input int extra_at, input int extra_kind, input int probe_at);
      lat = -1;
      yo  = 32'hxxxx_xxxx;
      @(negedge CLK);
      audio_ready = 1'b1;
      x           = xin;
      slot_en     = en;
      @(posedge CLK);
      #1;
      audio_ready = 1'b0;
      slot_en     = ~en;   // later enable changes must not affect this sample
      x           = 32'hDEAD_BEEF;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(posedge CLK);
         #1;
         audio_ready = 1'b0;
         clr_flags   = 1'b0;
         man_done    = 1'b0;
         if (cyc == extra_at) begin
            if (extra_kind == 0) begin
               audio_ready = 1'b1;
               clr_flags   = 1'b1;
            end else begin
               man_done = 1'b1;
               man_y    = 32'hBAD0_0BAD;
            end
         end
         if (cyc == probe_at) begin
            probe_x     = fx_x;
            probe_slot  = fx_slot;
            probe_start = fx_start;
            probe_busy  = busy;
         end
         if (y_valid === 1'b1) begin
            lat = cyc;
            yo  = y;
            break;
         end
      end
      audio_ready = 1'b0;
      clr_flags   = 1'b0;
      man_done    = 1'b0;
      @(posedge CLK);
      #1;
      check_val("y_valid_one_cycle", {63'd0, y_valid}, 64'd0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; yv_count = 0;
      resp_mode = 0; resp_d = 1;
      rst = 1'b1; audio_ready = 1'b0; x = 32'd0; slot_en = 4'd0;
      clr_flags = 1'b0; man_done = 1'b0; man_y = 32'd0;

      // Reset state.
      repeat (2) @(posedge CLK);
      #1;
      check_val("rst_y", y, 64'd0);
      check_val("rst_y_valid", y_valid, 64'd0);
      check_val("rst_fx_start", fx_start, 64'd0);
      check_val("rst_fx_x", fx_x, 64'd0);
      check_val("rst_fx_slot", fx_slot, 64'd0);
      check_val("rst_busy", busy, 64'd0);
      check_val("rst_indicator", indicator, 64'd0);
      check_val("rst_overrun", overrun, 64'd0);
      check_val("rst_fault", fault, 64'd0);
      @(negedge CLK);
      rst = 1'b0;

      // All slots bypassed.
      fs0 = fs_count;
      run_sample(32'h0000_1234, 4'b0000, 0, 0, 1);
      check_val("bypass_lat", lat, 64'd6);
      check_val("bypass_y", yo, 64'h1234);
      check_val("bypass_no_start", fs_count - fs0, 64'd0);
      check_val("bypass_busy_mid", probe_busy, 64'd1);
      check_val("bypass_busy_end", busy, 64'd0);

      // Single slot 2, answer x+1 after one wait cycle.
      resp_mode = 1; resp_d = 1;
      fs0 = fs_count;
      run_sample(32'h0000_0010, 4'b0100, 0, 0, 0);
      check_val("single_lat", lat, 64'd8);
      check_val("single_y", yo, 64'h11);
      check_val("single_starts", fs_count - fs0, 64'd1);
      check_val("single_slot", slot_log[fs0], 64'd2);
      check_val("single_fx_x", x_log[fs0], 64'h10);
      check_val("single_indicator", indicator, 64'b0100);

      // Chaining through all four slots, x*2 after three waits each.
      resp_mode = 2; resp_d = 3;
      fs0 = fs_count;
      run_sample(32'd1, 4'b1111, 0, 0, 0);
      check_val("chain_lat", lat, 64'd22);
      check_val("chain_y", yo, 64'd16);
      check_val("chain_starts", fs_count - fs0, 64'd4);
      check_val("chain_slot0", slot_log[fs0], 64'd0);
      check_val("chain_slot1", slot_log[fs0 + 1], 64'd1);
      check_val("chain_slot2", slot_log[fs0 + 2], 64'd2);
      check_val("chain_slot3", slot_log[fs0 + 3], 64'd3);
      check_val("chain_x1", x_log[fs0 + 1], 64'd2);
      check_val("chain_x3", x_log[fs0 + 3], 64'd8);
      check_val("chain_fault", fault, 64'd0);

      // Timeout on slot 0; a stray fx_done in the following SCAN is ignored.
      resp_mode = 0;
      run_sample(32'h0000_0055, 4'b0001, 66, 1, 30);
      check_val("to_lat", lat, 64'd71);
      check_val("to_y", yo, 64'h55);
      check_val("to_fault", fault, 64'd1);
      check_val("to_hold_x", probe_x, 64'h55);
      check_val("to_hold_slot", probe_slot, 64'd0);
      check_val("to_start_low", probe_start, 64'd0);
      @(negedge CLK);
      clr_flags = 1'b1;
      @(negedge CLK);
      clr_flags = 1'b0;
      check_val("clr_fault", fault, 64'd0);

      // Overrun: second strobe (with clr_flags) while busy; set must win.
      resp_mode = 1; resp_d = 1;
      fs0 = fs_count;
      yv0 = yv_count;
      run_sample(32'h0000_0020, 4'b0001, 2, 0, 0);
      check_val("ovr_lat", lat, 64'd8);
      check_val("ovr_y", yo, 64'h21);
      check_val("ovr_flag", overrun, 64'd1);
      repeat (20) @(posedge CLK);
      #1;
      check_val("ovr_one_result", yv_count - yv0, 64'd1);
      check_val("ovr_one_start", fs_count - fs0, 64'd1);
      check_val("ovr_idle", busy, 64'd0);
      @(negedge CLK);
      clr_flags = 1'b1;
      @(negedge CLK);
      clr_flags = 1'b0;
      check_val("clr_overrun", overrun, 64'd0);

      // Reset while waiting on the effect unit.
      resp_mode = 0;
      fs0 = fs_count;
      yv0 = yv_count;
      @(negedge CLK);
      audio_ready = 1'b1;
      x           = 32'h0000_0077;
      slot_en     = 4'b0001;
      @(posedge CLK);
      #1;
      audio_ready = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      check_val("mid_busy", busy, 64'd1);
      check_val("mid_issued", fs_count - fs0, 64'd1);
      rst = 1'b1;
      #1;
      check_val("mid_rst_fx_start", fx_start, 64'd0);
      check_val("mid_rst_fx_x", fx_x, 64'd0);
      check_val("mid_rst_busy", busy, 64'd0);
      check_val("mid_rst_y", y, 64'd0);
      check_val("mid_rst_indicator", indicator, 64'd0);
      @(negedge CLK);
      rst = 1'b0;
      repeat (80) @(posedge CLK);
      #1;
      check_val("mid_rst_no_y_valid", yv_count - yv0, 64'd0);
      check_val("mid_rst_idle", busy, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
